// File: rtl/bg_estimator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bg_estimator                                                             |
// | Sequentially accumulates per-PE RGB sums and divides by the pixel count  |
// | with bit-serial restoring dividers; results are held until Ack.          |
// | Optional build macro: BG_EST_ROUND_EN (round-half-up mean).              |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module bg_estimator #(
  parameter int NUM_PE     = 4,
  parameter int PIX_PER_PE = 4,
  parameter int SUM_W      = 16
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    Start,
  input  logic                    Ack,
  input  logic [SUM_W*NUM_PE-1:0] red_sum_in,
  input  logic [SUM_W*NUM_PE-1:0] green_sum_in,
  input  logic [SUM_W*NUM_PE-1:0] blue_sum_in,
  output logic [7:0]              red_exp,
  output logic [7:0]              green_exp,
  output logic [7:0]              blue_exp,
  output logic                    Done,
  output logic                    Qi,
  output logic                    Qa,
  output logic                    Qv,
  output logic                    Qd
);

  localparam int c_ACC_W = 24;
  localparam int c_REM_W = 17;
  localparam int c_IDX_W = $clog2(NUM_PE + 1);
  localparam logic [c_REM_W:0]   c_DIVISOR = 18'(NUM_PE * PIX_PER_PE);
  localparam logic [c_IDX_W-1:0] c_IDX_END = c_IDX_W'(NUM_PE);
`ifdef BG_EST_ROUND_EN
  localparam logic [c_ACC_W-1:0] c_PRELOAD = 24'((NUM_PE * PIX_PER_PE) / 2);
`else
  localparam logic [c_ACC_W-1:0] c_PRELOAD = '0;
`endif

  typedef enum logic [3:0] {
    S_IDLE  = 4'b0001,
    S_ACCUM = 4'b0010,
    S_DIV   = 4'b0100,
    S_DONE  = 4'b1000
  } state_t;

  state_t              r_state;
  state_t              w_state_nx;
  logic [c_IDX_W-1:0]  r_idx;
  logic [4:0]          r_bit_cnt;
  logic [c_ACC_W-1:0]  r_acc [3];
  logic [c_ACC_W-1:0]  r_dvd [3];
  logic [c_ACC_W-1:0]  r_quo [3];
  logic [c_REM_W-1:0]  r_rem [3];
  logic [7:0]          r_exp [3];

  logic [SUM_W*NUM_PE-1:0] w_bus [3];
  logic [SUM_W-1:0]        w_word [3];
  logic [c_REM_W-1:0]      w_rem_nx [3];
  logic [c_ACC_W-1:0]      w_quo_nx [3];
  logic [7:0]              w_sat [3];
  logic                    w_acc_end;

  assign w_bus[0]  = red_sum_in;
  assign w_bus[1]  = green_sum_in;
  assign w_bus[2]  = blue_sum_in;
  assign w_acc_end = (r_idx == c_IDX_END);

  // The extra ACCUM cycle at r_idx == NUM_PE moves the completed sums into the dividers.
  always_comb begin
    for (int c = 0; c < 3; c++) begin
      w_word[c] = '0;
      for (int k = 0; k < NUM_PE; k++) begin
        if (r_idx == c_IDX_W'(k)) w_word[c] = w_bus[c][k*SUM_W +: SUM_W];
      end
    end
  end

  for (genvar c = 0; c < 3; c++) begin : g_ch
    logic [c_REM_W:0] w_rem_sh;
    logic             w_ge;
    assign w_rem_sh    = {r_rem[c], r_dvd[c][c_ACC_W-1]};
    assign w_ge        = (w_rem_sh >= c_DIVISOR);
    assign w_rem_nx[c] = w_ge ? c_REM_W'(w_rem_sh - c_DIVISOR) : w_rem_sh[c_REM_W-1:0];
    assign w_quo_nx[c] = {r_quo[c][c_ACC_W-2:0], w_ge};
    assign w_sat[c]    = (|w_quo_nx[c][c_ACC_W-1:8]) ? 8'hFF : w_quo_nx[c][7:0];
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) r_state <= S_IDLE;
    else        r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    Qi         = 1'b0;
    Qa         = 1'b0;
    Qv         = 1'b0;
    Qd         = 1'b0;
    case (r_state)
      S_IDLE: begin
        Qi = 1'b1;
        if (Start) w_state_nx = S_ACCUM;
      end
      S_ACCUM: begin
        Qa = 1'b1;
        if (w_acc_end) w_state_nx = S_DIV;
      end
      S_DIV: begin
        Qv = 1'b1;
        if (r_bit_cnt == 5'd0) w_state_nx = S_DONE;
      end
      S_DONE: begin
        Qd = 1'b1;
        if (Ack) w_state_nx = S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase
    Done = Qd;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_idx     <= '0;
      r_bit_cnt <= '0;
      for (int c = 0; c < 3; c++) begin
        r_acc[c] <= '0;
        r_dvd[c] <= '0;
        r_quo[c] <= '0;
        r_rem[c] <= '0;
        r_exp[c] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (Start) begin
            r_idx <= '0;
            for (int c = 0; c < 3; c++) r_acc[c] <= c_PRELOAD;
          end
        end
        S_ACCUM: begin
          if (w_acc_end) begin
            r_bit_cnt <= 5'd23;
            for (int c = 0; c < 3; c++) begin
              r_dvd[c] <= r_acc[c];
              r_quo[c] <= '0;
              r_rem[c] <= '0;
            end
          end else begin
            r_idx <= r_idx + 1'b1;
            for (int c = 0; c < 3; c++) r_acc[c] <= r_acc[c] + c_ACC_W'(w_word[c]);
          end
        end
        S_DIV: begin
          r_bit_cnt <= r_bit_cnt - 1'b1;
          for (int c = 0; c < 3; c++) begin
            r_dvd[c] <= r_dvd[c] << 1;
            r_rem[c] <= w_rem_nx[c];
            r_quo[c] <= w_quo_nx[c];
            if (r_bit_cnt == 5'd0) r_exp[c] <= w_sat[c];
          end
        end
        default: ;
      endcase
    end
  end

  assign red_exp   = r_exp[0];
  assign green_exp = r_exp[1];
  assign blue_exp  = r_exp[2];

endmodule
`default_nettype wire

// File: tb/tb_bg_estimator.sv
`default_nettype none
// Testbench for bg_estimator: cycle-level behavioural model plus directed and randomized runs.
module tb_bg_estimator;

  localparam int NUM_PE = 4;
  localparam int PIX    = 4;
  localparam int SUM_W  = 16;
  localparam int N      = NUM_PE * PIX;
  localparam int LAT    = NUM_PE + 25;
`ifdef BG_EST_ROUND_EN
  localparam int RED_BASIC = 63;
`else
  localparam int RED_BASIC = 62;
`endif

  logic                    Clk;
  logic                    Reset, Start, Ack;
  logic [SUM_W*NUM_PE-1:0] red_sum_in, green_sum_in, blue_sum_in;
  logic [7:0]              red_exp, green_exp, blue_exp;
  logic                    Done, Qi, Qa, Qv, Qd;

  bg_estimator #(.NUM_PE(NUM_PE), .PIX_PER_PE(PIX), .SUM_W(SUM_W)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Ack(Ack),
    .red_sum_in(red_sum_in), .green_sum_in(green_sum_in), .blue_sum_in(blue_sum_in),
    .red_exp(red_exp), .green_exp(green_exp), .blue_exp(blue_exp),
    .Done(Done), .Qi(Qi), .Qa(Qa), .Qv(Qv), .Qd(Qd)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic int mean_of(input logic [SUM_W*NUM_PE-1:0] bus);
    int s;
    int q;
    s = 0;
    for (int k = 0; k < NUM_PE; k++) s += int'(bus[k*SUM_W +: SUM_W]);
`ifdef BG_EST_ROUND_EN
    s += N / 2;
`endif
    q = s / N;
    return (q > 255) ? 255 : q;
  endfunction

  // Model: 0 idle, 1 busy (m_t edges since Start), 2 done.
  int m_state = 0;
  int m_t     = 0;
  int m_exp [3] = '{0, 0, 0};
  int m_pend [3] = '{0, 0, 0};

  always @(posedge Clk) begin
    if (!Reset) begin
      m_state = 0;
      m_exp   = '{0, 0, 0};
    end else begin
      case (m_state)
        0: if (Start) begin
          m_state   = 1;
          m_t       = 0;
          m_pend[0] = mean_of(red_sum_in);
          m_pend[1] = mean_of(green_sum_in);
          m_pend[2] = mean_of(blue_sum_in);
        end
        1: begin
          m_t++;
          if (m_t == LAT) begin
            m_state = 2;
            m_exp   = m_pend;
          end
        end
        default: if (Ack) m_state = 0;
      endcase
    end
  end

  always @(posedge Clk) begin
    logic [28:0] req;
    #1;
    req = {m_state == 2, m_state == 0, (m_state == 1) && (m_t <= NUM_PE),
           (m_state == 1) && (m_t > NUM_PE), m_state == 2,
           8'(m_exp[0]), 8'(m_exp[1]), 8'(m_exp[2])};
    check("cycle", 32'({Done, Qi, Qa, Qv, Qd, red_exp, green_exp, blue_exp}), 32'(req));
  end

  task automatic set_basic();
    red_sum_in   = {16'd400, 16'd300, 16'd200, 16'd100};
    green_sum_in = {4{16'd16}};
    blue_sum_in  = '0;
  endtask

  task automatic randomize_buses();
    int lim;
    for (int k = 0; k < NUM_PE; k++) begin
      case ($urandom_range(0, 3))
        0: lim = 255;
        1: lim = 1023;
        2: lim = 4095;
        default: lim = 65535;
      endcase
      red_sum_in[k*SUM_W +: SUM_W]   = 16'($urandom_range(0, lim));
      green_sum_in[k*SUM_W +: SUM_W] = 16'($urandom_range(0, lim));
      blue_sum_in[k*SUM_W +: SUM_W]  = 16'($urandom_range(0, lim));
    end
  endtask

  task automatic run(input int ack_a, input int ack_b, input int st_at, input int rst_at,
                     input bit scramble, output int lat);
    Start = 1'b1;
    @(posedge Clk);
    #1;
    Start = 1'b0;
    lat = 0;
    forever begin
      @(negedge Clk);
      Ack   = (lat == ack_a) || (lat == ack_b);
      Start = (lat == st_at);
      if (scramble && lat == NUM_PE + 3) randomize_buses();
      if (lat == rst_at) Reset = 1'b0;
      @(posedge Clk);
      #1;
      lat++;
      if (Done || lat >= 200 || (rst_at >= 0 && lat > rst_at)) break;
    end
    Ack   = 1'b0;
    Start = 1'b0;
  endtask

  task automatic ack_after(input int delay);
    repeat (delay) @(negedge Clk);
    @(negedge Clk);
    Ack = 1'b1;
    @(negedge Clk);
    Ack = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    Reset = 1'b0; Start = 1'b0; Ack = 1'b0;
    red_sum_in = '0; green_sum_in = '0; blue_sum_in = '0;
    repeat (2) @(negedge Clk);
    check("reset_flags", 32'({Done, Qi, Qa, Qv, Qd}), 32'b01000);
    check("reset_exp", 32'({red_exp, green_exp, blue_exp}), 32'h0);
    Reset = 1'b1;
    @(negedge Clk);

    set_basic();
    run(-1, -1, -1, -1, 1'b0, lat);
    check("basic_latency", lat, LAT);
    check("basic_red", 32'(red_exp), RED_BASIC);
    check("basic_green", 32'(green_exp), 4);
    check("basic_blue", 32'(blue_exp), 0);
    ack_after(0);

    red_sum_in = '1; green_sum_in = '1; blue_sum_in = '1;
    run(-1, -1, -1, -1, 1'b0, lat);
    check("sat_latency", lat, LAT);
    check("sat_exp", 32'({red_exp, green_exp, blue_exp}), 32'hFFFFFF);
    ack_after(1);

    // Start held high for a whole run, then Ack and Start together.
    Start = 1'b1;
    @(posedge Clk);
    #1;
    lat = 0;
    while (!Done && lat < 200) begin
      @(posedge Clk);
      #1;
      lat++;
    end
    check("held_latency", lat, LAT);
    repeat (40) @(posedge Clk);
    #1;
    check("held_done", 32'({Done, Qd}), 32'b11);
    @(negedge Clk);
    Ack = 1'b1;
    @(posedge Clk);
    #1;
    check("ack_wins", 32'({Done, Qi}), 32'b01);
    @(negedge Clk);
    Ack = 1'b0; Start = 1'b0;
    @(posedge Clk);
    #1;
    check("no_rerun", 32'({Qi, Qa}), 32'b10);

    @(negedge Clk);
    run(2, 10, -1, -1, 1'b0, lat);
    check("ign_ack_latency", lat, LAT);
    ack_after(0);

    set_basic();
    @(negedge Clk);
    run(-1, -1, -1, 15, 1'b0, lat);
    check("rst_flags", 32'({Done, Qi, Qa, Qv, Qd}), 32'b01000);
    check("rst_exp", 32'({red_exp, green_exp, blue_exp}), 32'h0);
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    run(-1, -1, -1, -1, 1'b0, lat);
    check("rerun_latency", lat, LAT);
    check("rerun_exp", 32'({red_exp, green_exp, blue_exp}), 32'({8'(RED_BASIC), 8'd4, 8'd0}));
    ack_after(0);

    randomize_buses();
    repeat (50) @(negedge Clk);
    check("hold_exp", 32'({red_exp, green_exp, blue_exp}), 32'({8'(RED_BASIC), 8'd4, 8'd0}));
    check("hold_idle", 32'(Qi), 1);

    for (int i = 0; i < 20; i++) begin
      randomize_buses();
      @(negedge Clk);
      run(int'($urandom_range(0, 40)) - 10, int'($urandom_range(0, 27)),
          int'($urandom_range(0, 27)), -1, 1'($urandom_range(0, 1)), lat);
      check("rand_latency", lat, LAT);
      ack_after(int'($urandom_range(0, 3)));
    end

    @(negedge Clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bg_estimator.md
# bg_estimator

Computes the expected background colour (`red_exp`, `green_exp`, `blue_exp`) that is broadcast to every `pe` instance. It sits directly upstream of the `pe` array. It collects the per-PE channel sums produced in the PEs' SUM phase, accumulates them sequentially, and divides by the total pixel count with a bit-serial restoring divider. It then holds the 8-bit means until the controller acknowledges.

## Interface
Parameters:
- `NUM_PE`, 4: number of PE sum words on each input bus.
- `PIX_PER_PE`, 4: pixels summed by each PE. The divisor is N = NUM_PE*PIX_PER_PE, and 1 ≤ N < 2^16.
- `SUM_W`, 16: width of one PE sum word.

Ports:
- `Clk` in 1: single clock; all state updates on posedge.
- `Reset` in 1: **asynchronous, active-low** reset. Asserted when 0.
- `Start` in 1: begin an estimate. Sampled only in IDLE.
- `Ack` in 1: release results. Sampled only in DONE.
- `red_sum_in`, `green_sum_in`, `blue_sum_in` in SUM_W*NUM_PE: concatenated PE sums; word k is bits [k*SUM_W +: SUM_W].
- `red_exp`, `green_exp`, `blue_exp` out 8: mean channel values, registered.
- `Done` out 1: high in DONE.
- `Qi`, `Qa`, `Qv`, `Qd` out 1 each: one-hot state flags for IDLE, ACCUM, DIV, DONE.

## Operation
- State machine is one-hot: IDLE → ACCUM → DIV → DONE → IDLE.
- **IDLE.** On Start=1: clear the three 24-bit accumulators (ACC_W=24), clear pe_idx, and go to ACCUM.
- **ACCUM.** One cycle per PE:
  - Each accumulator adds word pe_idx of its bus, zero-extended.
  - pe_idx increments.
  - After pe_idx==NUM_PE-1 is added, load the divider and go to DIV.
- **DIV.** Three parallel 24-iteration restoring dividers with divisor N:
  - Each has a 24-bit dividend, 24-bit quotient and 17-bit remainder.
  - Each cycle shifts one dividend bit (MSB first) into the remainder.
  - If remainder ≥ N, subtract N and set the quotient bit.
  - bit_cnt counts 23 down to 0. After the bit_cnt==0 iteration, go to DONE.
- **Saturation.** On DONE entry, each `*_exp` loads min(quotient, 255).
- **DONE.** Done=1. On Ack=1, go to IDLE.
- `*_exp` change only on DONE entry and hold through IDLE and the next run.
- Input buses must stay stable from the Start edge until DIV is entered. The block does not latch the full buses.
- Ignored inputs:
  - Start in ACCUM, DIV or DONE.
  - Ack in IDLE, ACCUM or DIV.
  - Start and Ack both high in DONE: Ack wins → IDLE; Start must be re-presented in IDLE.
- Reset asserted at any time (mid-ACCUM or mid-DIV included) immediately forces IDLE and clears accumulators, counters and the divider.

## Timing
- Reset values: `red_exp`=`green_exp`=`blue_exp`=0, Done=0, Qi=1, Qa=Qv=Qd=0.
- Start sampled at edge T0 → ACCUM from T0. Words are added at edges T1..T_NUM_PE. DIV runs 24 edges. Done rises after edge T(NUM_PE+24+1).
- Latency from the Start edge to Done=1 is NUM_PE+25 cycles; with defaults this is 29.
- `*_exp` are valid on the same cycle Done=1.
- Ack sampled at edge Ta → Done=0, Qi=1 after Ta.
- Earliest accepted restart is the edge after Ta.

## Configuration
- `BG_EST_ROUND_EN` defined:
  - In the IDLE→ACCUM transition, each accumulator is preloaded with floor(N/2) instead of 0.
  - The result is round-half-up: mean = floor((sum + N/2)/N).
- Not defined: accumulators clear to 0 and the result truncates, mean = floor(sum/N).
- Latency is identical in both builds.

## Test plan
All scenarios use defaults, N=16.
- **Basic mean.** Red words 100, 200, 300, 400 (total 1000); green all 16 (total 64); blue all 0.
  - Without macro: Done at cycle 29 with red=62, green=4, blue=0.
  - With macro: red=63, green=4.
- **Saturation.** All words 65535 (total 262140): `*_exp`=255 for all channels.
- **Handshake.**
  - Start held through the whole run with Ack=0: one run only; Done stays high indefinitely.
  - Ack=1 together with Start=1 in DONE → IDLE, no new run.
  - Start pulsed the next cycle → new run.
- **Ignored Ack.** Ack pulsed during ACCUM and DIV: no effect; Done still rises at cycle 29.
- **Reset mid-DIV.** Assert Reset=0 at cycle 15 of a run: next sample shows Qi=1, Done=0 and `*_exp`=0. Then run the basic-mean stimulus: same results as scenario 1.
- **Hold.** After Ack, change the input buses and leave Start=0 for 50 cycles: `*_exp` unchanged.
